// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // $clog2 that never returns 0, so single-entry indices still get one bit.
  function automatic int clog2_safe(input int value);
    int result;
    result = (value <= 1) ? 1 : $clog2(value);
    return result;
  endfunction

  localparam int WDOG_W_DEFAULT = clog2_safe(256 + 1);

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotating-priority picker: searches last+1, last+2, ... (mod N).
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // First requester after the previous owner wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: N initiators share one target, grant held for
// the whole cyc, with a watchdog that aborts transactions never acknowledged.
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int N_INITIATORS  = 2,
  parameter int TIMEOUT       = 256
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]      adr,
  input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]      dat_w,
  output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]      dat_r,
  input  logic [N_INITIATORS-1:0]                    cyc,
  input  logic [N_INITIATORS-1:0]                    stb,
  input  logic [N_INITIATORS-1:0]                    we,
  input  logic [N_INITIATORS*(WB_DATA_WIDTH/8)-1:0]  sel,
  output logic [N_INITIATORS-1:0]                    ack,
  output logic [N_INITIATORS-1:0]                    err,
  output logic [WB_ADDR_WIDTH-1:0]                   tadr,
  output logic [WB_DATA_WIDTH-1:0]                   tdat_w,
  output logic [WB_DATA_WIDTH/8-1:0]                 tsel,
  output logic                                       tcyc,
  output logic                                       tstb,
  output logic                                       twe,
  input  logic [WB_DATA_WIDTH-1:0]                   tdat_r,
  input  logic                                       tack,
  input  logic                                       terr,
  output logic [N_INITIATORS-1:0]                    gnt
);

  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int N  = N_INITIATORS;
  localparam int IW = clog2_safe(N);
  localparam int WW = clog2_safe(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LIMIT = WW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [WW-1:0] WDOG_MAX   = {WW{1'b1}};
  localparam logic [IW-1:0] LAST_INIT  = IW'(N - 1);

  arb_state_e    state;
  logic [IW-1:0] last;
  logic [WW-1:0] wdog;
  logic [N-1:0]  req;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          owned;
  logic          own_cyc;
  logic          own_stb;
  logic          wdog_fire;

  assign req = cyc & stb;

  wb_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req        (req),
    .last       (last),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // While owned, last always holds the owner index.
  assign owned     = (state == ARB_OWNED);
  assign own_cyc   = cyc[last];
  assign own_stb   = stb[last];
  assign wdog_fire = (TIMEOUT != 0) && owned && own_stb && !tack && !terr &&
                     (wdog == WDOG_LIMIT);

  assign dat_r = {N{tdat_r}};

  // Route the owner's request to the target and the response back to the owner only.
  always_comb begin
    tcyc   = 1'b0;
    tstb   = 1'b0;
    twe    = 1'b0;
    tadr   = '0;
    tdat_w = '0;
    tsel   = '0;
    ack    = '0;
    err    = '0;
    if (owned) begin
      tcyc      = own_cyc;
      tstb      = own_stb;
      twe       = we[last];
      tadr      = adr[last*AW +: AW];
      tdat_w    = dat_w[last*DW +: DW];
      tsel      = sel[last*SW +: SW];
      ack[last] = tack & own_cyc;
      err[last] = terr | wdog_fire;
    end else begin
      tcyc = 1'b0;
    end
  end

  // Arbitration state, grant, rotation pointer and saturating watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      last  <= LAST_INIT;
      wdog  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          wdog <= '0;
          if (pick_any) begin
            gnt   <= pick_onehot;
            last  <= pick_idx;
            state <= ARB_OWNED;
          end
        end
        ARB_OWNED: begin
          if (!own_cyc || wdog_fire) begin
            state <= ARB_IDLE;
            gnt   <= '0;
            wdog  <= '0;
          end else if (tack || terr) begin
            wdog <= '0;
          end else if (own_stb && (wdog != WDOG_MAX)) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state <= ARB_IDLE;
          gnt   <= '0;
          wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Self-checking bench for wb_arbiter_rr: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_wb_arbiter_rr;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] dat_w;
  logic [N*DW-1:0] dat_r;
  logic [N-1:0]    cyc, stb, we, ack, err, gnt;
  logic [N*SW-1:0] sel;
  logic [AW-1:0]   tadr;
  logic [DW-1:0]   tdat_w, tdat_r;
  logic [SW-1:0]   tsel;
  logic            tcyc, tstb, twe, tack, terr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the target, who was served last, unanswered strobe cycles.
  int m_owner;
  int m_last;
  int m_nores;

  wb_arbiter_rr #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .N_INITIATORS  (N),
    .TIMEOUT       (TO)
  ) dut (
    .clock (clock), .reset (reset),
    .adr (adr), .dat_w (dat_w), .dat_r (dat_r),
    .cyc (cyc), .stb (stb), .we (we), .sel (sel),
    .ack (ack), .err (err),
    .tadr (tadr), .tdat_w (tdat_w), .tsel (tsel),
    .tcyc (tcyc), .tstb (tstb), .twe (twe),
    .tdat_r (tdat_r), .tack (tack), .terr (terr),
    .gnt (gnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion within bound");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0; adr = '0; dat_w = '0; sel = '0;
    tack = 1'b0; terr = 1'b0; tdat_r = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_owner = -1;
    m_last  = N - 1;
    m_nores = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cyc = '1; stb = '1; tack = 1'b1;
    tick();
    #1;
    n_cmp++; if (tcyc !== 1'b0) begin n_bad++; $display("FAIL reset_tcyc: got %0b want 0", tcyc); end
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_cmp++; if (ack !== 2'b00 || err !== 2'b00) begin n_bad++; $display("FAIL reset_resp: ack %b err %b want 00/00", ack, err); end
    n_cmp++; if (tadr !== 32'h0) begin n_bad++; $display("FAIL reset_tadr: got %h want 0", tadr); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    cyc = 2'b10; stb = 2'b10; we = 2'b00;
    adr[AW +: AW] = 32'h0000_1004;
    #1;
    n_cmp++; if (tcyc !== 1'b0) begin n_bad++; $display("FAIL single_c0_tcyc: got %0b want 0", tcyc); end
    tick(); #1;
    n_cmp++; if (tcyc !== 1'b1 || tadr !== 32'h0000_1004) begin n_bad++; $display("FAIL single_c1_req: tcyc %0b tadr %h want 1/00001004", tcyc, tadr); end
    n_cmp++; if (gnt !== 2'b10 || ack !== 2'b00) begin n_bad++; $display("FAIL single_c1_gnt: gnt %b ack %b want 10/00", gnt, ack); end
    tick(); #1;
    n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL single_c2_ack: got %b want 00", ack); end
    tick();
    tack = 1'b1; tdat_r = 32'h0000_BEEF;
    #1;
    n_cmp++; if (ack !== 2'b10) begin n_bad++; $display("FAIL single_c3_ack: got %b want 10", ack); end
    n_cmp++; if (dat_r[DW +: DW] !== 32'h0000_BEEF) begin n_bad++; $display("FAIL single_c3_dat: got %h want 0000beef", dat_r[DW +: DW]); end
    tick();
    tack = 1'b0; cyc = 2'b00; stb = 2'b00;
    #1;
    n_cmp++; if (tcyc !== 1'b0) begin n_bad++; $display("FAIL single_drop_tcyc: got %0b want 0", tcyc); end
    tick(); #1;
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL single_release_gnt: got %b want 00", gnt); end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      int w;
      cyc = '1; stb = '1; tack = 1'b0;
      w = 0;
      #1;
      while (gnt === '0 && w < 4) begin
        tick(); #1;
        w++;
      end
      exp_g = N'(1 << (t % N));
      n_cmp++; if (gnt !== exp_g) begin n_bad++; $display("FAIL contention_gnt%0d: got %b want %b", t, gnt, exp_g); end
      tack = 1'b1;
      #1;
      n_cmp++; if (ack !== exp_g || err !== 2'b00) begin n_bad++; $display("FAIL contention_ack%0d: ack %b err %b want %b/00", t, ack, err, exp_g); end
      tick();
      cyc = ~exp_g; stb = ~exp_g; tack = 1'b0;
      #1;
      n_cmp++; if (tcyc !== 1'b0) begin n_bad++; $display("FAIL contention_drop%0d: tcyc %0b want 0", t, tcyc); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_block_hold();
    do_reset();
    cyc = 2'b11; stb = 2'b11;
    tick();
    for (int b = 0; b < 4; b++) begin
      tack = 1'b1;
      #1;
      n_cmp++; if (gnt !== 2'b01 || ack !== 2'b01) begin n_bad++; $display("FAIL block_beat%0d: gnt %b ack %b want 01/01", b, gnt, ack); end
      tick();
    end
    tack = 1'b0; cyc = 2'b10; stb = 2'b10;
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL block_drop_gnt: got %b want 01", gnt); end
    tick(); #1;
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL block_dead_gnt: got %b want 00", gnt); end
    tick(); #1;
    n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL block_handoff_gnt: got %b want 10", gnt); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_watchdog();
    logic [N-1:0] exp_e;
    do_reset();
    cyc = 2'b10; stb = 2'b10;
    tick();
    for (int c = 1; c <= TO; c++) begin
      if (c == 3) begin cyc = 2'b11; stb = 2'b11; end
      #1;
      exp_e = (c == TO) ? 2'b10 : 2'b00;
      n_cmp++; if (err !== exp_e || tcyc !== 1'b1) begin n_bad++; $display("FAIL wdog_c%0d: err %b tcyc %0b want %b/1", c, err, tcyc, exp_e); end
      tick();
    end
    #1;
    n_cmp++; if (tcyc !== 1'b0 || gnt !== 2'b00 || err !== 2'b00) begin n_bad++; $display("FAIL wdog_abort: tcyc %0b gnt %b err %b want 0/00/00", tcyc, gnt, err); end
    tick(); #1;
    n_cmp++; if (gnt !== 2'b01 || tcyc !== 1'b1) begin n_bad++; $display("FAIL wdog_next: gnt %b tcyc %0b want 01/1", gnt, tcyc); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    cyc = 2'b10; stb = 2'b10;
    tick(); tick();
    reset = 1'b1; cyc = 2'b11; stb = 2'b11; tack = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (tcyc !== 1'b0 || gnt !== 2'b00) begin n_bad++; $display("FAIL midreset_drop: tcyc %0b gnt %b want 0/00", tcyc, gnt); end
    n_cmp++; if (ack !== 2'b00 || err !== 2'b00) begin n_bad++; $display("FAIL midreset_resp: ack %b err %b want 00/00", ack, err); end
    tick(); #1;
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL midreset_first: gnt %b want 01", gnt); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    logic [N-1:0] cyc_n, e_gnt, e_ack, e_err;
    logic [AW+DW+SW+2:0] e_req, got_req;
    logic fire;
    bit found;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++)
        cyc_n[k] = cyc[k] ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
      cyc = cyc_n;
      stb = cyc_n & N'($urandom_range(3) != 0 ? 2'b11 : 2'($urandom));
      we = N'($urandom);
      adr = {$urandom, $urandom};
      dat_w = {$urandom, $urandom};
      sel = N*SW'($urandom);
      tdat_r = $urandom;
      tack = (i < 200) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      terr = ($urandom_range(31) == 0);
      e_gnt = '0; e_ack = '0; e_err = '0; e_req = '0; fire = 1'b0;
      if (m_owner >= 0) begin
        fire = stb[m_owner] && !tack && !terr && (m_nores == TO - 1);
        e_gnt[m_owner] = 1'b1;
        e_ack[m_owner] = tack && cyc[m_owner];
        e_err[m_owner] = terr || fire;
        e_req = {cyc[m_owner], stb[m_owner], we[m_owner], adr[m_owner*AW +: AW],
                 dat_w[m_owner*DW +: DW], sel[m_owner*SW +: SW]};
      end
      #1;
      got_req = {tcyc, tstb, twe, tadr, tdat_w, tsel};
      n_cmp++; if (got_req !== e_req) begin n_bad++; $display("FAIL rand_req@%0d: got %h want %h", i, got_req, e_req); end
      n_cmp++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL rand_gnt@%0d: got %b want %b", i, gnt, e_gnt); end
      n_cmp++; if (ack !== e_ack || err !== e_err) begin n_bad++; $display("FAIL rand_resp@%0d: ack %b err %b want %b/%b", i, ack, err, e_ack, e_err); end
      n_cmp++; if (dat_r !== {N{tdat_r}}) begin n_bad++; $display("FAIL rand_datr@%0d: got %h want %h", i, dat_r, {N{tdat_r}}); end
      if (m_owner < 0) begin
        found = 1'b0;
        for (int j = 1; j <= N; j++) begin
          int k;
          k = (m_last + j) % N;
          if (!found && cyc[k] && stb[k]) begin
            found = 1'b1; m_owner = k; m_last = k; m_nores = 0;
          end
        end
      end else if (!cyc[m_owner] || fire) begin
        m_owner = -1; m_nores = 0;
      end else if (tack || terr) begin
        m_nores = 0;
      end else if (stb[m_owner]) begin
        m_nores++;
      end
      tick();
    end
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_block_hold();
    test_watchdog();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
